// File: rtl/arp_cam_ctrl.sv
// arp_cam_ctrl: round-robin arbiter serializing TX/CPU lookups and ARP learns onto one CAM port,
// with search-then-write learning and occupancy tracking.
module arp_cam_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_req,
  input  logic [ADDR_WIDTH-1:0] tx_key,
  output logic tx_ack,
  output logic tx_hit,
  output logic [DATA_WIDTH-1:0] tx_mac,
  input  logic cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_key,
  output logic cpu_ack,
  output logic cpu_hit,
  output logic [DATA_WIDTH-1:0] cpu_mac,
  input  logic lrn_req,
  input  logic [ADDR_WIDTH-1:0] lrn_key,
  input  logic [DATA_WIDTH-1:0] lrn_mac,
  output logic lrn_ack,
  output logic [1:0] lrn_status,
  output logic [$clog2(DEPTH+1)-1:0] entry_count,
  output logic full,
  output logic cam_search_en,
  output logic [ADDR_WIDTH-1:0] cam_search_key,
  input  logic [DATA_WIDTH-1:0] cam_search_data,
  input  logic cam_match,
  output logic cam_write_en,
  output logic [ADDR_WIDTH-1:0] cam_write_key,
  output logic [DATA_WIDTH-1:0] cam_write_data
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [1:0] TX = 2'd0, CPU = 2'd1, LRN = 2'd2;
  localparam logic [1:0] ADDED = 2'd0, DUP = 2'd1, FULL_DROP = 2'd2;
  typedef enum logic [2:0] {IDLE, SEARCH, RESULT, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] ptr, id, gnt, p1, p2;
  logic [2:0] elig;
  logic [ADDR_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] mac;
  logic lrn_add;
  // a requester still holding req during its own ack pulse is not re-granted
  assign elig = {lrn_req & ~lrn_ack, cpu_req & ~cpu_ack, tx_req & ~tx_ack};
  assign p1 = (ptr == LRN) ? TX : ptr + 2'd1;
  assign p2 = (p1 == LRN) ? TX : p1 + 2'd1;
  assign gnt = elig[ptr] ? ptr : elig[p1] ? p1 : p2;
  assign full = entry_count == CW'(DEPTH);
  assign lrn_add = (id == LRN) && !cam_match && !full;
  assign cam_search_en = state == SEARCH;
  assign cam_search_key = key;
  assign cam_write_en = state == WRITE;
  assign cam_write_key = key;
  assign cam_write_data = mac;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |elig ? SEARCH : IDLE;
      SEARCH:  state_nx = RESULT;
      RESULT:  state_nx = lrn_add ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= TX;
      id <= TX;
      key <= '0;
      mac <= '0;
      tx_ack <= 1'b0;
      tx_hit <= 1'b0;
      tx_mac <= '0;
      cpu_ack <= 1'b0;
      cpu_hit <= 1'b0;
      cpu_mac <= '0;
      lrn_ack <= 1'b0;
      lrn_status <= ADDED;
      entry_count <= '0;
    end else begin
      tx_ack <= 1'b0;
      cpu_ack <= 1'b0;
      lrn_ack <= 1'b0;
      if (state == IDLE && |elig) begin
        id <= gnt;
        ptr <= (gnt == LRN) ? TX : gnt + 2'd1;
        key <= (gnt == TX) ? tx_key : (gnt == CPU) ? cpu_key : lrn_key;
        if (gnt == LRN) mac <= lrn_mac;
      end
      if (state == RESULT && id == TX) begin
        tx_ack <= 1'b1;
        tx_hit <= cam_match;
        tx_mac <= cam_match ? cam_search_data : '0;
      end
      if (state == RESULT && id == CPU) begin
        cpu_ack <= 1'b1;
        cpu_hit <= cam_match;
        cpu_mac <= cam_match ? cam_search_data : '0;
      end
      // a duplicate key wins over a full table
      if (state == RESULT && id == LRN && !lrn_add) begin
        lrn_ack <= 1'b1;
        lrn_status <= cam_match ? DUP : FULL_DROP;
      end
      if (state == WRITE) begin
        lrn_ack <= 1'b1;
        lrn_status <= ADDED;
        entry_count <= full ? entry_count : entry_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_arp_cam_ctrl.sv
// tb_arp_cam_ctrl: randomized bench for arp_cam_ctrl with a behavioural CAM and a key->mac reference table.
module tb_arp_cam_ctrl;
  localparam int AW = 32, DW = 48, D = 16, CW = $clog2(D+1);
  logic clk, rst_n;
  logic tx_req, cpu_req, lrn_req;
  logic [AW-1:0] tx_key, cpu_key, lrn_key;
  logic [DW-1:0] lrn_mac, tx_mac, cpu_mac;
  logic tx_ack, tx_hit, cpu_ack, cpu_hit, lrn_ack, full;
  logic [1:0] lrn_status;
  logic [CW-1:0] entry_count;
  logic cam_search_en, cam_match, cam_write_en;
  logic [AW-1:0] cam_search_key, cam_write_key;
  logic [DW-1:0] cam_search_data, cam_write_data;
  int total, bad, wr_cnt, both_cnt, last_gnt;
  logic [DW-1:0] ref_tab [logic [AW-1:0]];
  logic [AW-1:0] cam_k [D];
  logic [DW-1:0] cam_d [D];
  int cam_n;

  arp_cam_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_req(tx_req), .tx_key(tx_key), .tx_ack(tx_ack), .tx_hit(tx_hit), .tx_mac(tx_mac),
    .cpu_req(cpu_req), .cpu_key(cpu_key), .cpu_ack(cpu_ack), .cpu_hit(cpu_hit), .cpu_mac(cpu_mac),
    .lrn_req(lrn_req), .lrn_key(lrn_key), .lrn_mac(lrn_mac), .lrn_ack(lrn_ack), .lrn_status(lrn_status),
    .entry_count(entry_count), .full(full),
    .cam_search_en(cam_search_en), .cam_search_key(cam_search_key), .cam_search_data(cam_search_data),
    .cam_match(cam_match), .cam_write_en(cam_write_en), .cam_write_key(cam_write_key),
    .cam_write_data(cam_write_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // CAM: one-cycle search result, garbage data on a miss, appends on write
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_n <= 0;
      cam_match <= 1'b0;
      cam_search_data <= '0;
    end else begin
      cam_match <= 1'b0;
      cam_search_data <= DW'({$urandom(), $urandom()});
      if (cam_search_en)
        for (int i = 0; i < D; i++)
          if (i < cam_n && cam_k[i] == cam_search_key) begin
            cam_match <= 1'b1;
            cam_search_data <= cam_d[i];
          end
      if (cam_write_en && cam_n < D) begin
        cam_k[cam_n] <= cam_write_key;
        cam_d[cam_n] <= cam_write_data;
        cam_n <= cam_n + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (cam_write_en) wr_cnt++;
    if (cam_search_en && cam_write_en) both_cnt++;
  end

  task automatic lookup(input int who, input logic [AW-1:0] k, input string nm);
    int lat;
    bit seen, stray, exp_hit;
    logic hit;
    logic [DW-1:0] mac, exp_mac;
    exp_hit = ref_tab.exists(k);
    exp_mac = exp_hit ? ref_tab[k] : '0;
    @(negedge clk);
    if (who == 0) begin tx_key = k; tx_req = 1; end
    else begin cpu_key = k; cpu_req = 1; end
    lat = 0; seen = 0; stray = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lrn_ack || (who == 0 ? cpu_ack : tx_ack)) stray = 1;
      seen = (who == 0) ? tx_ack : cpu_ack;
    end
    hit = (who == 0) ? tx_hit : cpu_hit;
    mac = (who == 0) ? tx_mac : cpu_mac;
    tx_req = 0; cpu_req = 0;
    last_gnt = who;
    total++;
    if (!seen || lat != 3) begin bad++; $display("FAIL %s latency: got=%0d want=3 seen=%0d", nm, lat, seen); end
    total++;
    if (hit !== exp_hit || mac !== exp_mac) begin
      bad++; $display("FAIL %s result: hit=%0d mac=%h want hit=%0d mac=%h", nm, hit, mac, exp_hit, exp_mac);
    end
    total++;
    if (stray) begin bad++; $display("FAIL %s stray_ack: got=1 want=0", nm); end
  endtask

  task automatic learn(input logic [AW-1:0] k, input logic [DW-1:0] m, input string nm);
    int lat, w0, exp_lat;
    bit seen, stray;
    logic [1:0] exp_st, st;
    exp_st = ref_tab.exists(k) ? 2'd1 : (ref_tab.num() >= D) ? 2'd2 : 2'd0;
    exp_lat = (exp_st == 2'd0) ? 4 : 3;
    w0 = wr_cnt;
    @(negedge clk);
    lrn_key = k; lrn_mac = m; lrn_req = 1;
    lat = 0; seen = 0; stray = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (tx_ack || cpu_ack) stray = 1;
      seen = lrn_ack;
    end
    st = lrn_status;
    lrn_req = 0;
    last_gnt = 2;
    if (exp_st == 2'd0) ref_tab[k] = m;
    total++;
    if (!seen || lat != exp_lat) begin bad++; $display("FAIL %s latency: got=%0d want=%0d seen=%0d", nm, lat, exp_lat, seen); end
    total++;
    if (st !== exp_st) begin bad++; $display("FAIL %s status: got=%0d want=%0d", nm, st, exp_st); end
    total++;
    if (wr_cnt - w0 != ((exp_st == 2'd0) ? 1 : 0) || stray) begin
      bad++; $display("FAIL %s writes: got=%0d stray=%0d want=%0d", nm, wr_cnt - w0, stray, exp_st == 2'd0);
    end
    total++;
    if (entry_count !== CW'(ref_tab.num()) || full !== (ref_tab.num() == D)) begin
      bad++; $display("FAIL %s count: got=%0d full=%0d want=%0d", nm, entry_count, full, ref_tab.num());
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    total++;
    if ({tx_ack, cpu_ack, lrn_ack, tx_hit, cpu_hit, cam_search_en, cam_write_en, full} !== 8'h00) begin
      bad++; $display("FAIL %s flags: got=%b want=00000000", nm,
        {tx_ack, cpu_ack, lrn_ack, tx_hit, cpu_hit, cam_search_en, cam_write_en, full});
    end
    total++;
    if (tx_mac !== '0 || cpu_mac !== '0 || lrn_status !== 2'd0 || entry_count !== '0) begin
      bad++; $display("FAIL %s values: tx_mac=%h cpu_mac=%h st=%0d cnt=%0d want all 0", nm, tx_mac, cpu_mac, lrn_status, entry_count);
    end
    total++;
    if (cam_search_key !== '0 || cam_write_key !== '0 || cam_write_data !== '0) begin
      bad++; $display("FAIL %s latches: skey=%h wkey=%h wdata=%h want 0", nm, cam_search_key, cam_write_key, cam_write_data);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    last_gnt = 2;
  endtask

  task automatic test_learn_lookup;
    learn(32'h0A000001, 48'h001122334455, "learn_add");
    lookup(0, 32'h0A000001, "tx_hit");
  endtask

  task automatic test_dup;
    learn(32'h0A000001, 48'hAAAAAAAAAAAA, "learn_dup");
    lookup(0, 32'h0A000001, "tx_after_dup");
  endtask

  task automatic test_cpu_miss;
    lookup(1, 32'hC0A80001, "cpu_miss");
  endtask

  task automatic test_random;
    logic [AW-1:0] k;
    for (int i = 0; i < 40; i++) begin
      k = 32'h0B000000 | 32'($urandom_range(0, 11));
      case ($urandom_range(0, 2))
        0: lookup(0, k, "rnd_tx");
        1: lookup(1, k, "rnd_cpu");
        default: learn(k, DW'({$urandom(), $urandom()}), "rnd_lrn");
      endcase
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 40 && ref_tab.num() < D; i++)
      learn(32'h0C000000 + 32'(i), DW'({$urandom(), $urandom()}), "fill");
    learn(32'h0D000000, 48'h0000DEADBEEF, "learn_full");
    learn(32'h0A000001, 48'h555555555555, "dup_when_full");
    lookup(0, 32'h0D000000, "tx_dropped_key");
  endtask

  task automatic test_back_to_back;
    int n, gap, cyc, id, nack, exp, w0;
    bit ok;
    w0 = wr_cnt;
    @(negedge clk);
    tx_key = 32'h0A000001; cpu_key = 32'hC0A80001;
    lrn_key = 32'h0A000001; lrn_mac = 48'h123456789ABC;
    tx_req = 1; cpu_req = 1; lrn_req = 1;
    exp = (last_gnt + 1) % 3;
    n = 0; gap = 0; cyc = 0;
    while (n < 9 && cyc < 80) begin
      @(negedge clk);
      cyc++; gap++;
      nack = int'(tx_ack) + int'(cpu_ack) + int'(lrn_ack);
      if (nack != 0) begin
        id = tx_ack ? 0 : cpu_ack ? 1 : 2;
        total++;
        if (nack != 1 || id != exp || gap != (n == 0 ? 3 : 4)) begin
          bad++; $display("FAIL rr_order #%0d: id=%0d acks=%0d gap=%0d want id=%0d acks=1 gap=%0d", n, id, nack, gap, exp, n == 0 ? 3 : 4);
        end
        ok = (id == 0) ? (tx_hit === 1'b1 && tx_mac === ref_tab[32'h0A000001]) :
             (id == 1) ? (cpu_hit === 1'b0 && cpu_mac === '0) : (lrn_status === 2'd1);
        total++;
        if (!ok) begin
          bad++; $display("FAIL rr_result #%0d id=%0d: tx=%0d/%h cpu=%0d/%h st=%0d", n, id, tx_hit, tx_mac, cpu_hit, cpu_mac, lrn_status);
        end
        if (n == 8) begin tx_req = 0; cpu_req = 0; lrn_req = 0; end
        n++; gap = 0;
        exp = (exp + 1) % 3;
        last_gnt = id;
      end
    end
    tx_req = 0; cpu_req = 0; lrn_req = 0;
    total++;
    if (n != 9 || wr_cnt != w0) begin bad++; $display("FAIL rr_count: acks=%0d writes=%0d want acks=9 writes=0", n, wr_cnt - w0); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check_idle_outputs("reset_clear");
    rst_n = 1;
    ref_tab.delete();
    last_gnt = 2;
    @(negedge clk);
    lrn_key = 32'h0A000001; lrn_mac = 48'h001122334455; lrn_req = 1;
    cyc = 0;
    while (!cam_write_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!cam_write_en) begin bad++; $display("FAIL mid_write_reached: got=0 want=1"); end
    rst_n = 0;
    lrn_req = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (lrn_ack !== 1'b0) begin bad++; $display("FAIL mid_reset_ack: got=%0d want=0", lrn_ack); end
    end
    check_idle_outputs("mid_reset");
    rst_n = 1;
    learn(32'h0A000001, 48'h001122334455, "relearn");
  endtask

  initial begin
    total = 0; bad = 0; wr_cnt = 0; both_cnt = 0; last_gnt = 2;
    rst_n = 0;
    tx_req = 0; cpu_req = 0; lrn_req = 0;
    tx_key = '0; cpu_key = '0; lrn_key = '0; lrn_mac = '0;
    test_reset;
    test_learn_lookup;
    test_dup;
    test_cpu_miss;
    test_random;
    test_full;
    test_back_to_back;
    test_reset_mid;
    total++;
    if (both_cnt != 0) begin bad++; $display("FAIL search_write_overlap: got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
